// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM encoding, memory geometry defaults and requester ids.
package dm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } dm_state_e;

   localparam int   DM_DEPTH_LOG2 = 12;
   localparam int   DM_BE_W       = 4;
   localparam logic M_LSU         = 1'b0;
   localparam logic M_AUX         = 1'b1;

   // Misaligned word access or any address bit beyond the array is illegal.
   function automatic logic dm_addr_err(input logic [31:0] addr,
                                        input int unsigned depth_log2);
      return (addr[1:0] != 2'b00) || ((addr >> (depth_log2 + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured
// when both ask, and flips to the loser whenever a grant is consumed.
module rr_arb2
   import dm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant,
   output logic       grant_id
);

   logic r_ptr;
   logic w_id;

   always_comb begin
      w_id = (req == 2'b11) ? r_ptr : req[1];
   end

   assign grant_id = w_id;
   assign grant    = {w_id, ~w_id} & {2{|req}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_ptr <= M_LSU;
      else if (update)
         r_ptr <= ~w_id;
   end

endmodule

// File: rtl/dm_arbiter.sv
// Arbiter/sequencer between the LSU (m0), the aux master (m1) and the
// single-port data memory: one access in flight, IDLE -> ISSUE -> RESP.
module dm_arbiter
   import dm_pkg::*;
#(
   parameter int DEPTH_LOG2 = DM_DEPTH_LOG2,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [DATA_W/8-1:0]   m0_be,
   input  logic [31:0]           m0_addr,
   input  logic [7:0]            m0_asid,
   input  logic [DATA_W-1:0]     m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_W-1:0]     m0_rdata,
   output logic                  m0_err,

   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [DATA_W/8-1:0]   m1_be,
   input  logic [31:0]           m1_addr,
   input  logic [7:0]            m1_asid,
   input  logic [DATA_W-1:0]     m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_W-1:0]     m1_rdata,
   output logic                  m1_err,

   output logic                  mem_en,
   output logic                  mem_we,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [DEPTH_LOG2-1:0] mem_addr,
   output logic [7:0]            mem_asid,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   localparam int BE_W = DATA_W / 8;

   dm_state_e             r_state;
   dm_state_e             w_nxt;

   logic [1:0]            w_req;
   logic [1:0]            w_grant;
   logic                  w_gid;
   logic                  w_any;
   logic                  w_latch;

   logic                  w_sel_we;
   logic                  w_sel_err;
   logic [BE_W-1:0]       w_sel_be;
   logic [31:0]           w_sel_addr;
   logic [7:0]            w_sel_asid;
   logic [DATA_W-1:0]     w_sel_wdata;

   logic                  r_id;
   logic                  r_we;
   logic                  r_err;

   logic                  r_mem_en;
   logic                  r_mem_we;
   logic [BE_W-1:0]       r_mem_be;
   logic [DEPTH_LOG2-1:0] r_mem_addr;
   logic [7:0]            r_mem_asid;
   logic [DATA_W-1:0]     r_mem_wdata;

   logic [1:0]            w_gnt;
   logic [1:0]            w_rvalid;
   logic [1:0]            w_err;
   logic [DATA_W-1:0]     w_rdata0;
   logic [DATA_W-1:0]     w_rdata1;

   assign w_req   = {m1_req, m0_req};
   assign w_any   = |w_req;
   assign w_latch = w_any && ((r_state == ST_IDLE) || (r_state == ST_RESP));

   rr_arb2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .req      (w_req),
      .update   (w_latch),
      .grant    (w_grant),
      .grant_id (w_gid)
   );

   assign w_sel_we    = w_grant[1] ? m1_we    : m0_we;
   assign w_sel_be    = w_grant[1] ? m1_be    : m0_be;
   assign w_sel_addr  = w_grant[1] ? m1_addr  : m0_addr;
   assign w_sel_asid  = w_grant[1] ? m1_asid  : m0_asid;
   assign w_sel_wdata = w_grant[1] ? m1_wdata : m0_wdata;
   assign w_sel_err   = dm_addr_err(w_sel_addr, DEPTH_LOG2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_IDLE:  w_nxt = w_any ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: w_nxt = ST_RESP;
         ST_RESP:  w_nxt = w_any ? ST_ISSUE : ST_IDLE;
         default:  w_nxt = ST_IDLE;
      endcase
   end

   // The mem_* registers are loaded on the latch edge so they are valid for
   // exactly the ISSUE cycle; async reset kills an in-flight strobe at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_id        <= M_LSU;
         r_we        <= 1'b0;
         r_err       <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= '0;
         r_mem_addr  <= '0;
         r_mem_asid  <= '0;
         r_mem_wdata <= '0;
      end else if (w_latch) begin
         r_id        <= w_gid;
         r_we        <= w_sel_we;
         r_err       <= w_sel_err;
         r_mem_en    <= ~w_sel_err;
         r_mem_we    <= w_sel_we & ~w_sel_err;
         r_mem_be    <= w_sel_err ? '0 : w_sel_be;
         r_mem_addr  <= w_sel_err ? '0 : w_sel_addr[DEPTH_LOG2+1:2];
         r_mem_asid  <= w_sel_err ? '0 : w_sel_asid;
         r_mem_wdata <= w_sel_err ? '0 : w_sel_wdata;
      end else begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= '0;
         r_mem_addr  <= '0;
         r_mem_asid  <= '0;
         r_mem_wdata <= '0;
      end
   end

   always_comb begin
      w_gnt    = '0;
      w_rvalid = '0;
      w_err    = '0;
      w_rdata0 = '0;
      w_rdata1 = '0;
      case (r_state)
         ST_ISSUE: w_gnt[r_id] = 1'b1;
         ST_RESP: begin
            w_rvalid[r_id] = 1'b1;
            w_err[r_id]    = r_err;
            if (!r_err && !r_we) begin
               if (r_id == M_AUX)
                  w_rdata1 = mem_rdata;
               else
                  w_rdata0 = mem_rdata;
            end
         end
         default: ;
      endcase
   end

   assign m0_gnt    = w_gnt[0];
   assign m0_rvalid = w_rvalid[0];
   assign m0_err    = w_err[0];
   assign m0_rdata  = w_rdata0;
   assign m1_gnt    = w_gnt[1];
   assign m1_rvalid = w_rvalid[1];
   assign m1_err    = w_err[1];
   assign m1_rdata  = w_rdata1;

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_be    = r_mem_be;
   assign mem_addr  = r_mem_addr;
   assign mem_asid  = r_mem_asid;
   assign mem_wdata = r_mem_wdata;

endmodule
